// File: rtl/vec_regfile_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vec_pkg
//  Brief    : Shared sizes, types and opcodes for the 16-lane vector datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package vec_pkg;
    localparam int LANES  = 16;
    localparam int LANE_W = 32;
    localparam int VEC_W  = LANES * LANE_W;
    localparam int NREGS  = 4;
    localparam int AW     = $clog2(NREGS);

    typedef logic [AW-1:0]    addr_t;
    typedef logic [VEC_W-1:0] vec_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WR_HI = 1'b1
    } wb_state_t;

    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;
endpackage
`default_nettype wire

// File: rtl/vec_regfile_wb_if.sv
`default_nettype none
// ============================================================================
//  Module   : vec_regfile_wb_if
//  Brief    : Operand read, ALU writeback and host load signals of the regfile.
//  Revision : 1.0 - initial release
// ============================================================================
interface vec_regfile_wb_if;
    import vec_pkg::*;

    addr_t rs1_addr;
    addr_t rs2_addr;
    vec_t  rd1_data;
    vec_t  rd2_data;
    logic  wb_valid;
    logic  wb_ready;
    addr_t wb_rd;
    vec_t  wb_lo;
    vec_t  wb_hi;
    logic  wb_hi_en;
    logic  ld_valid;
    logic  ld_ready;
    addr_t ld_addr;
    vec_t  ld_data;
    logic  busy;

    modport master (
        output rs1_addr, rs2_addr, wb_valid, wb_rd, wb_lo, wb_hi, wb_hi_en,
               ld_valid, ld_addr, ld_data,
        input  rd1_data, rd2_data, wb_ready, ld_ready, busy
    );

    modport slave (
        input  rs1_addr, rs2_addr, wb_valid, wb_rd, wb_lo, wb_hi, wb_hi_en,
               ld_valid, ld_addr, ld_data,
        output rd1_data, rd2_data, wb_ready, ld_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/vec_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module   : vec_reg_bank
//  Brief    : NREGS x VEC_W storage, one write port, two registered
//             write-first read ports, synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
module vec_reg_bank
    import vec_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic we,
    input  wire addr_t waddr,
    input  wire vec_t wdata,
    input  wire addr_t raddr1,
    input  wire addr_t raddr2,
    output vec_t      rdata1,
    output vec_t      rdata2
);
    vec_t r_mem [NREGS];
    vec_t r_rd1;
    vec_t r_rd2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else begin
            if (we) begin
                r_mem[waddr] <= wdata;
            end
            // Same-cycle write to the selected register is forwarded to the read port
            r_rd1 <= (we && (waddr == raddr1)) ? wdata : r_mem[raddr1];
            r_rd2 <= (we && (waddr == raddr2)) ? wdata : r_mem[raddr2];
        end
    end

    assign rdata1 = r_rd1;
    assign rdata2 = r_rd2;
endmodule
`default_nettype wire

// File: rtl/vec_regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module   : vec_regfile_wb
//  Brief    : Vector register file with two-beat lo/hi writeback and host load.
//  Revision : 1.0 - initial release
// ============================================================================
module vec_regfile_wb
    import vec_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    vec_regfile_wb_if.slave bus
);
    wb_state_t r_state;
    wb_state_t w_state_nxt;
    addr_t     r_hold_addr;
    vec_t      r_hold_data;

    logic  w_wb_ready;
    logic  w_ld_ready;
    logic  w_busy;
    logic  w_wb_hs;
    logic  w_we;
    addr_t w_waddr;
    vec_t  w_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wb_ready  = 1'b0;
        w_ld_ready  = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_wb_ready = rst_n;
                w_ld_ready = rst_n & ~bus.wb_valid;
                if (bus.wb_valid && rst_n && bus.wb_hi_en) begin
                    w_state_nxt = WR_HI;
                end
            end
            WR_HI: begin
                w_busy      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_wb_hs = bus.wb_valid & w_wb_ready;

    // Only one source owns the write port: pending high half, then ALU low half, then host
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (w_busy) begin
            w_we    = 1'b1;
            w_waddr = r_hold_addr;
            w_wdata = r_hold_data;
        end else if (w_wb_hs) begin
            w_we    = 1'b1;
            w_waddr = bus.wb_rd;
            w_wdata = bus.wb_lo;
        end else if (bus.ld_valid && w_ld_ready) begin
            w_we    = 1'b1;
            w_waddr = bus.ld_addr;
            w_wdata = bus.ld_data;
        end
    end

    // Neighbour address wraps naturally because NREGS is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_addr <= '0;
            r_hold_data <= '0;
        end else if (w_wb_hs) begin
            r_hold_addr <= bus.wb_rd + addr_t'(1);
            r_hold_data <= bus.wb_hi;
        end
    end

    vec_reg_bank u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (w_we),
        .waddr  (w_waddr),
        .wdata  (w_wdata),
        .raddr1 (bus.rs1_addr),
        .raddr2 (bus.rs2_addr),
        .rdata1 (bus.rd1_data),
        .rdata2 (bus.rd2_data)
    );

    assign bus.wb_ready = w_wb_ready;
    assign bus.ld_ready = w_ld_ready;
    assign bus.busy     = w_busy;
endmodule
`default_nettype wire
